// File: rtl/dmem_access_ctrl_pkg.sv
// Shared constants, FSM encoding and store-lane helpers for the MEM-stage data-memory controller.
// Size codes follow the funct3 load/store encoding; funct3[1:0] carries the access size.
package dmem_access_ctrl_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/acknowledge port: the controller is the master, the memory the slave.
interface dmem_access_ctrl_if;
  import dmem_access_ctrl_pkg::*;

  logic                      mem_req;
  logic                      mem_we;
  logic [REG_DATA_WIDTH-1:0] mem_addr;
  logic [REG_DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]                mem_wstrb;
  logic [REG_DATA_WIDTH-1:0] mem_rdata;
  logic                      mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/dmem_access_ctrl_load_align.sv
// Picks the byte/halfword lane out of a read word and sign- or zero-extends it; purely combinational.
module dmem_access_ctrl_load_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{off, 3'b000} +: 8];
  assign half_lane = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   data = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  data = {24'h0, byte_lane};
      F3_LHU:  data = {16'h0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: issues req/ack accesses, stalls until ack or timeout,
// returns extended load data and flags misaligned and timed-out accesses.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Branch_in,
  input  logic                      MemRead_in,
  input  logic                      MemtoReg_in,
  input  logic                      MemWrite_in,
  input  logic                      RegWrite_in,
  input  logic [REG_DATA_WIDTH-1:0] ALU_result_in,
  input  logic                      ALU_zero_in,
  input  logic [REG_DATA_WIDTH-1:0] read_reg_data_2_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  input  logic [2:0]                funct3_in,
  dmem_access_ctrl_if.master        mem,
  output logic                      stall,
  output logic                      PCSrc,
  output logic [REG_DATA_WIDTH-1:0] load_data_out,
  output logic [REG_DATA_WIDTH-1:0] ALU_result_out,
  output logic                      RegWrite_out,
  output logic                      MemtoReg_out,
  output logic [REG_ADDR_WIDTH-1:0] rd_out,
  output logic                      misalign_err,
  output logic                      bus_err
);

  // The IDLE request cycle is the first counted cycle, so BUSY gives up one count early.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [29:0] hold_addr;
  logic [31:0] hold_wdata;
  logic [3:0]  hold_wstrb;
  logic        hold_we;
  logic [2:0]  hold_funct3;
  logic [1:0]  hold_off;

  logic        pending;
  logic        misaligned;
  logic        idle_acc;
  logic        busy;
  logic        timeout;
  logic        complete;
  logic        cur_we;
  logic [1:0]  cur_off;
  logic [2:0]  cur_funct3;
  logic [3:0]  in_wstrb;
  logic [31:0] aligned_data;

  assign pending    = MemRead_in | MemWrite_in;
  assign misaligned = is_misaligned(funct3_in[1:0], ALU_result_in[1:0]);
  assign idle_acc   = ~rst & (state == IDLE) & pending & ~misaligned;
  assign busy       = ~rst & (state == BUSY);
  assign timeout    = busy & ~mem.mem_ack & (tmo_cnt == TMO_LAST);
  assign complete   = (idle_acc | busy) & mem.mem_ack;
  assign in_wstrb   = MemWrite_in ? store_strb(funct3_in[1:0], ALU_result_in[1:0]) : 4'b0000;

  // IDLE drives the port straight from EX/MEM; BUSY replays the captured request.
  assign mem.mem_req   = idle_acc | (busy & ~timeout);
  assign mem.mem_we    = busy ? hold_we : (idle_acc & MemWrite_in);
  assign mem.mem_addr  = busy ? {hold_addr, 2'b00} : {ALU_result_in[31:2], 2'b00};
  assign mem.mem_wdata = busy ? hold_wdata : store_wdata(funct3_in[1:0], read_reg_data_2_in);
  assign mem.mem_wstrb = busy ? hold_wstrb : (idle_acc ? in_wstrb : 4'b0000);

  assign stall = (idle_acc & ~mem.mem_ack) | (busy & ~mem.mem_ack & ~timeout);

  assign cur_we     = busy ? hold_we     : MemWrite_in;
  assign cur_off    = busy ? hold_off    : ALU_result_in[1:0];
  assign cur_funct3 = busy ? hold_funct3 : funct3_in;

  dmem_access_ctrl_load_align u_load_align (
    .rdata  (mem.mem_rdata),
    .off    (cur_off),
    .funct3 (cur_funct3),
    .data   (aligned_data)
  );

  assign load_data_out  = (complete & ~cur_we) ? aligned_data : '0;
  assign misalign_err   = ~rst & (state == IDLE) & pending & misaligned;
  assign RegWrite_out   = RegWrite_in & ~misalign_err & ~timeout;
  assign PCSrc          = Branch_in & ALU_zero_in;
  assign ALU_result_out = ALU_result_in;
  assign MemtoReg_out   = MemtoReg_in;
  assign rd_out         = rd_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      hold_addr   <= '0;
      hold_wdata  <= '0;
      hold_wstrb  <= '0;
      hold_we     <= 1'b0;
      hold_funct3 <= '0;
      hold_off    <= '0;
      bus_err     <= 1'b0;
    end else if (state == IDLE) begin
      if (idle_acc && !mem.mem_ack) begin
        state       <= BUSY;
        tmo_cnt     <= '0;
        hold_addr   <= ALU_result_in[31:2];
        hold_wdata  <= store_wdata(funct3_in[1:0], read_reg_data_2_in);
        hold_wstrb  <= in_wstrb;
        hold_we     <= MemWrite_in;
        hold_funct3 <= funct3_in;
        hold_off    <= ALU_result_in[1:0];
      end
    end else begin
      if (mem.mem_ack) begin
        state   <= IDLE;
        tmo_cnt <= '0;
      end else if (timeout) begin
        state   <= IDLE;
        tmo_cnt <= '0;
        bus_err <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized and directed bench for dmem_access_ctrl against a lane/arithmetic reference model.
module tb_dmem_access_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        Branch_in, MemRead_in, MemtoReg_in, MemWrite_in, RegWrite_in, ALU_zero_in;
  logic [31:0] ALU_result_in, read_reg_data_2_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        stall, PCSrc, RegWrite_out, MemtoReg_out, misalign_err, bus_err;
  logic [31:0] load_data_out, ALU_result_out;
  logic [4:0]  rd_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl_if mem_if ();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                (clk),
    .rst                (rst),
    .Branch_in          (Branch_in),
    .MemRead_in         (MemRead_in),
    .MemtoReg_in        (MemtoReg_in),
    .MemWrite_in        (MemWrite_in),
    .RegWrite_in        (RegWrite_in),
    .ALU_result_in      (ALU_result_in),
    .ALU_zero_in        (ALU_zero_in),
    .read_reg_data_2_in (read_reg_data_2_in),
    .rd_in              (rd_in),
    .funct3_in          (funct3_in),
    .mem                (mem_if),
    .stall              (stall),
    .PCSrc              (PCSrc),
    .load_data_out      (load_data_out),
    .ALU_result_out     (ALU_result_out),
    .RegWrite_out       (RegWrite_out),
    .MemtoReg_out       (MemtoReg_out),
    .rd_out             (rd_out),
    .misalign_err       (misalign_err),
    .bus_err            (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] s;
    int nb, off;
    nb = nbytes(f3);
    off = addr % 4;
    s = '0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + nb) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] w;
    int nb;
    nb = nbytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * (addr % 4));
    if (nbytes(f3) == 1) begin
      v = {24'h0, v[7:0]};
      if (!f3[2] && v[7]) v[31:8] = '1;
    end else if (nbytes(f3) == 2) begin
      v = {16'h0, v[15:0]};
      if (!f3[2] && v[15]) v[31:16] = '1;
    end
    return v;
  endfunction

  // Runs one access; the memory acks w cycles after the first request cycle (w > TMO never acks).
  task automatic run_acc(input string tag, input logic rd, input logic wr, input logic rw,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int w, input bit scramble);
    bit mis, tmo, done;
    int k, stalls, lim;
    logic br, zr;
    mis = (addr % nbytes(f3)) != 0;
    tmo = w > TMO;
    lim = tmo ? TMO : w;
    done = 0; k = 0; stalls = 0;
    br = 1'($urandom); zr = 1'($urandom);
    MemRead_in = rd; MemWrite_in = wr; RegWrite_in = rw; funct3_in = f3;
    ALU_result_in = addr; read_reg_data_2_in = data; rd_in = 5'($urandom);
    MemtoReg_in = rd; Branch_in = br; ALU_zero_in = zr;
    mem_if.mem_rdata = rdata;
    while (!done) begin
      mem_if.mem_ack = !mis && (k == w);
      if (scramble && k > 0) begin
        ALU_result_in = $urandom;
        read_reg_data_2_in = $urandom;
      end
      #4;
      if (k == 0) begin
        chk({tag, ".pcsrc"}, PCSrc, br & zr);
        chk({tag, ".alu_out"}, ALU_result_out, addr);
        chk({tag, ".rd_out"}, rd_out, rd_in);
        chk({tag, ".m2r_out"}, MemtoReg_out, rd);
        chk({tag, ".mis_err"}, misalign_err, mis);
      end
      if (mis) begin
        chk({tag, ".mis_req"}, mem_if.mem_req, 0);
        chk({tag, ".mis_stall"}, stall, 0);
        chk({tag, ".mis_regwr"}, RegWrite_out, 0);
        done = 1;
      end else if (k == lim && tmo) begin
        chk({tag, ".tmo_req"}, mem_if.mem_req, 0);
        chk({tag, ".tmo_stall"}, stall, 0);
        chk({tag, ".tmo_regwr"}, RegWrite_out, 0);
        done = 1;
      end else begin
        chk({tag, ".req"}, mem_if.mem_req, 1);
        chk({tag, ".stall"}, stall, k != lim);
        chk({tag, ".addr"}, mem_if.mem_addr, addr & ~32'h3);
        chk({tag, ".we"}, mem_if.mem_we, wr);
        chk({tag, ".wstrb"}, mem_if.mem_wstrb, wr ? m_strb(f3, addr) : 4'b0000);
        if (wr) chk({tag, ".wdata"}, mem_if.mem_wdata, m_wdata(f3, data));
        if (k == lim) begin
          chk({tag, ".load"}, load_data_out, (rd && !wr) ? m_load(f3, addr, rdata) : 32'h0);
          chk({tag, ".regwr"}, RegWrite_out, rw);
          done = 1;
        end else begin
          chk({tag, ".load_busy"}, load_data_out, 0);
        end
      end
      stalls += int'(stall);
      @(posedge clk); #1;
      k++;
    end
    if (!mis) chk({tag, ".stall_cnt"}, stalls, lim);
    mem_if.mem_ack = 1'b0;
    MemRead_in = 1'b0; MemWrite_in = 1'b0; RegWrite_in = 1'b0;
  endtask

  task automatic idle_cycle(input string tag, input logic ack, input logic exp_bus_err);
    mem_if.mem_ack = ack;
    #4;
    chk({tag, ".req"}, mem_if.mem_req, 0);
    chk({tag, ".stall"}, stall, 0);
    chk({tag, ".load"}, load_data_out, 0);
    chk({tag, ".mis_err"}, misalign_err, 0);
    chk({tag, ".bus_err"}, bus_err, exp_bus_err);
    @(posedge clk); #1;
    mem_if.mem_ack = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic        rd, wr;
    int          sel;

    rst = 1'b1;
    {Branch_in, MemRead_in, MemtoReg_in, MemWrite_in, RegWrite_in, ALU_zero_in} = '0;
    ALU_result_in = '0; read_reg_data_2_in = '0; rd_in = '0; funct3_in = '0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    idle_cycle("reset", 1'b0, 1'b0);
    rst = 1'b0;

    run_acc("lw_zw",  1, 0, 1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    run_acc("lb_w3",  1, 0, 1, 3'b000, 32'h103, 32'h0, 32'h80AA5511, 3, 0);
    run_acc("lbu_w3", 1, 0, 1, 3'b100, 32'h103, 32'h0, 32'h80AA5511, 3, 0);
    run_acc("sh_w2",  0, 1, 0, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2, 1);
    run_acc("lw_mis", 1, 0, 1, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
    idle_cycle("post_mis", 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      rd = (sel != 1);
      wr = (sel != 0);
      if (wr) f3 = 3'($urandom_range(0, 2));
      else case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      a = $urandom;
      run_acc("rand", rd, wr, 1'($urandom), f3, a, $urandom, $urandom,
              $urandom_range(0, TMO), 1'($urandom));
    end
    idle_cycle("rand_end", 1'b1, 1'b0);

    run_acc("timeout", 1, 0, 1, 3'b010, 32'h300, 32'h0, 32'h0, 100, 0);
    repeat (3) idle_cycle("bus_err_hold", 1'b0, 1'b1);
    run_acc("after_tmo", 1, 0, 1, 3'b010, 32'h304, 32'h0, 32'h0BADF00D, 1, 0);
    idle_cycle("bus_err_sticky", 1'b0, 1'b1);

    // Park in BUSY, reset for one cycle, then deliver a stale ack.
    MemRead_in = 1'b1; funct3_in = 3'b010; ALU_result_in = 32'h40; RegWrite_in = 1'b1;
    mem_if.mem_rdata = 32'h55555555;
    #4;
    chk("rst_busy.stall0", stall, 1);
    @(posedge clk); #1;
    #4;
    chk("rst_busy.req1", mem_if.mem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1; MemRead_in = 1'b0; RegWrite_in = 1'b0;
    #4;
    chk("rst_busy.req_rst", mem_if.mem_req, 0);
    chk("rst_busy.stall_rst", stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle("late_ack", 1'b1, 1'b0);
    run_acc("lw_after_rst", 1, 0, 1, 3'b010, 32'h44, 32'h0, 32'hCAFEF00D, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
